// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronised RX line, mid-bit sampling, one-cycle valid/error pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module uart_rx_byte #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);

    localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CNT = BAUD_CNT / 2;
    localparam int CNT_W    = $clog2(BAUD_CNT);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_next;
    logic             sync1, sync2, dly;
    logic             falling;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             sample_pt, cnt_wrap;
    logic             pend_ok, pend_err;

    assign falling   = ~sync2 & dly;
    assign sample_pt = (baud_cnt == CNT_W'(HALF_CNT - 1));
    assign cnt_wrap  = (baud_cnt == CNT_W'(BAUD_CNT - 1));
    assign rx_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            dly   <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (falling) state_next = START;
            START: begin
                if (sample_pt && sync2) state_next = IDLE;
                else if (cnt_wrap)      state_next = DATA;
            end
`ifdef UART_RX_PARITY_EN
            DATA:   if (cnt_wrap && bit_idx == 3'd7) state_next = PARITY;
            PARITY: if (cnt_wrap) state_next = STOP;
`else
            DATA:   if (cnt_wrap && bit_idx == 3'd7) state_next = STOP;
`endif
            // Leave at mid-stop so a start edge arriving half a bit early is still seen.
            STOP:  if (sample_pt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            pend_ok   <= 1'b0;
            pend_err  <= 1'b0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (state == IDLE || state_next == IDLE || cnt_wrap) baud_cnt <= '0;
            else                                                 baud_cnt <= baud_cnt + 1'b1;

            if (state == START)                bit_idx <= '0;
            else if (state == DATA && cnt_wrap) bit_idx <= bit_idx + 1'b1;

            if (state == DATA && sample_pt) shift_reg <= {sync2, shift_reg[7:1]};

            pend_ok  <= (state == STOP) && sample_pt && sync2;
            pend_err <= (state == STOP) && sample_pt && !sync2;
            if (state == STOP && sample_pt && sync2) rx_data <= shift_reg;

            rx_valid     <= pend_ok;
            rx_frame_err <= pend_err;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad, pend_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad       <= 1'b0;
            pend_perr     <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            if (state == PARITY && sample_pt) par_bad <= (sync2 != ^shift_reg);
            pend_perr     <= (state == STOP) && sample_pt && par_bad;
            rx_parity_err <= pend_perr;
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomised self-checking bench for uart_rx_byte; expected events come from a frame-level queue model.
module tb_uart_rx_byte;

    localparam int BAUD_CNT = 50_000_000 / 115200;
    localparam int HALF_CNT = BAUD_CNT / 2;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_LAT = 3 + 10 * BAUD_CNT + HALF_CNT + 1;
`else
    localparam int EXP_LAT = 3 + 9 * BAUD_CNT + HALF_CNT + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err, rx_busy;

    uart_rx_byte #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err), .rx_busy(rx_busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         err;
        bit         perr;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] exp_data = 8'h00;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         valid_cyc = 0;
    int         last_start_cyc = 0;
    bit         prev_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every output pulse must match the oldest outstanding frame outcome.
    always @(negedge clk) begin
        bit  pulse;
        ev_t e;
        pulse = rx_valid | rx_frame_err | rx_parity_err;
        if (pulse) begin
            if (prev_pulse) check("pulse_width", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, rx_valid, rx_frame_err, rx_parity_err}, 0);
            end else begin
                e = exp_q.pop_front();
                if (!e.err) exp_data = e.data;
                check("rx_valid", rx_valid, !e.err);
                check("rx_frame_err", rx_frame_err, e.err);
                check("rx_parity_err", rx_parity_err, e.perr);
                check("rx_data", rx_data, exp_data);
                if (rx_valid) valid_cyc = cyc;
            end
        end
        prev_pulse = pulse;
    end

    task automatic drive_bit(input logic v, input bit chk_busy);
        uart_rxd = v;
        if (chk_busy) begin
            repeat (HALF_CNT) @(posedge clk);
            #1;
            check("rx_busy_frame", rx_busy, 1);
            repeat (BAUD_CNT - HALF_CNT) @(posedge clk);
            #1;
        end else begin
            repeat (BAUD_CNT) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit par_flip, input bit chk_busy);
        ev_t e;
        e.data = b;
        e.err  = !stop_v;
`ifdef UART_RX_PARITY_EN
        e.perr = par_flip;
`else
        e.perr = 1'b0;
`endif
        exp_q.push_back(e);
        last_start_cyc = cyc;
        drive_bit(1'b0, chk_busy);
        for (int i = 0; i < 8; i++) drive_bit(b[i], chk_busy);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip, chk_busy);
`endif
        drive_bit(stop_v, 1'b0);
        uart_rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] f0;
        logic [7:0] rb;
        f0 = 8'hF0;

        #5;
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_busy", rx_busy, 0);
        check("reset_pulses", {rx_valid, rx_frame_err, rx_parity_err}, 0);
        idle(4);
        rst_n = 1'b1;
        idle(20);

        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        check("latency_55", valid_cyc - last_start_cyc, EXP_LAT);
        check("queue_after_55", exp_q.size(), 0);
        idle(30);

        // Short low glitch is rejected at the start-bit midpoint.
        uart_rxd = 1'b0;
        idle(100);
        check("glitch_busy_mid", rx_busy, 1);
        uart_rxd = 1'b1;
        idle(HALF_CNT + 3 - 100);
        check("glitch_busy_end", rx_busy, 0);
        idle(BAUD_CNT);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check("data_after_frame_err", rx_data, 8'h55);
        idle(BAUD_CNT);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check("queue_after_b2b", exp_q.size(), 0);
        idle(50);

        // Reset in the middle of a frame, after data bit 3.
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(f0[i], 1'b0);
        rst_n = 1'b0;
        uart_rxd = 1'b1;
        exp_data = 8'h00;
        #1;
        check("midreset_rx_data", rx_data, 0);
        check("midreset_rx_busy", rx_busy, 0);
        check("midreset_pulses", {rx_valid, rx_frame_err, rx_parity_err}, 0);
        idle(5);
        rst_n = 1'b1;
        idle(2 * BAUD_CNT);
        check("after_release_busy", rx_busy, 0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        check("rx_data_81", rx_data, 8'h81);
        idle(50);

        // Break: line held low well past a frame gives one framing error only.
        begin
            ev_t e;
            e.data = 8'h00; e.err = 1'b1; e.perr = 1'b0;
            exp_q.push_back(e);
        end
        uart_rxd = 1'b0;
        idle(13 * BAUD_CNT);
        check("break_busy", rx_busy, 0);
        uart_rxd = 1'b1;
        idle(BAUD_CNT);
        check("data_after_break", rx_data, 8'h81);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        idle(20);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(20);
`endif

        for (int k = 0; k < 5; k++) begin
            rb = 8'($urandom);
            send_frame(rb, ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), 1'b0);
            idle($urandom_range(0, 40));
        end

        idle(BAUD_CNT);
        check("queue_final", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
